// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array feed path.
//   skew_state_e : operand loader phases (LOAD, STREAM, DONE)
//   cnt_width    : counter width for n distinct values, never below 1 bit
//   e_width      : width of the element index counter
//   t_width      : width of the wavefront cycle counter
package systolic_pkg;

  typedef enum logic [1:0] {
    LOAD,
    STREAM,
    DONE
  } skew_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned e_width(input int unsigned rows, input int unsigned depth);
    return cnt_width(rows * depth);
  endfunction

  function automatic int unsigned t_width(input int unsigned rows, input int unsigned depth);
    return cnt_width(rows + depth - 1);
  endfunction

endpackage

// File: rtl/counter_up.sv
// Saturating up-counter 0 .. max_p with synchronous clear.
//   clk_i    : clock
//   reset_ni : asynchronous active-low reset
//   clr_i    : synchronous clear to 0, wins over inc_i
//   inc_i    : advance by one; holds at max_p
//   cnt_o    : current count (registered)
//   term_c   : count equals max_p
module counter_up
  import systolic_pkg::*;
#(
  parameter int unsigned max_p = 1,
  localparam int unsigned cnt_w = cnt_width(max_p + 1)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [cnt_w-1:0] cnt_o,
  output logic             term_c
);

  logic [cnt_w-1:0] cnt_q;

  assign term_c = (cnt_q == cnt_w'(max_p));
  assign cnt_o  = cnt_q;

  // Count register; saturates at the terminal value.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !term_c) begin
      cnt_q <= cnt_q + cnt_w'(1);
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand loader for the systolic array: buffers one rows_p x depth_p matrix
// received as a row-major element stream, then replays it as a diagonal
// wavefront with row r delayed by r cycles.
//   clk_i    : clock
//   reset_ni : asynchronous active-low reset
//   en_i     : global enable; low freezes all state
//   flush_i  : synchronous abort back to LOAD (beats en_i)
//   valid_i  : input element valid
//   data_i   : input element
//   ready_o  : element accepted this cycle when valid_i is high
//   valid_o  : per-row output valid, bit r = row r
//   data_o   : row r at bits [r*width_p +: width_p]
//   done_o   : one-cycle pulse after the wavefront completes
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned width_p = 8,
  parameter int unsigned rows_p  = 2,
  parameter int unsigned depth_p = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       en_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic [rows_p-1:0]          valid_o,
  output logic [rows_p*width_p-1:0]  data_o,
  output logic                       done_o
);

  localparam int unsigned n_elem = rows_p * depth_p;
  localparam int unsigned t_last = rows_p + depth_p - 2;
  localparam int unsigned e_w    = e_width(rows_p, depth_p);
  localparam int unsigned t_w    = t_width(rows_p, depth_p);

  skew_state_e state_q, state_d;

  logic [e_w-1:0] e_q;
  logic [t_w-1:0] t_q;
  logic           e_term_c, t_term_c;
  logic           accept_c, t_inc_c;
  int unsigned    t_ext;

  logic [width_p-1:0] buf_q [n_elem];

  // Ready is held low while reset is asserted, not only by the LOAD state.
  assign ready_o  = reset_ni & en_i & (state_q == LOAD);
  assign accept_c = ready_o & valid_i;
  assign t_inc_c  = en_i & (state_q == STREAM);
  assign done_o   = (state_q == DONE);

  // Element index: wraps to 0 on the final accepted element.
  counter_up #(.max_p(n_elem - 1)) u_e_cnt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_i    (flush_i | (accept_c & e_term_c)),
    .inc_i    (accept_c),
    .cnt_o    (e_q),
    .term_c   (e_term_c)
  );

  // Wavefront cycle: runs only while streaming and enabled.
  counter_up #(.max_p(t_last)) u_t_cnt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_i    (flush_i | (t_inc_c & t_term_c)),
    .inc_i    (t_inc_c),
    .cnt_o    (t_q),
    .term_c   (t_term_c)
  );

  // State register; flush overrides the enable.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= LOAD;
    end else if (flush_i) begin
      state_q <= LOAD;
    end else if (en_i) begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (accept_c && e_term_c) state_d = STREAM;
      STREAM:  if (t_term_c) state_d = DONE;
      DONE:    state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Operand buffer, row-major by element index; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (accept_c && !flush_i) begin
      buf_q[e_q] <= data_i;
    end
  end

  assign t_ext = 32'(t_q);

  // Row r shows column t-r while 0 <= t-r < depth_p, otherwise zero.
  for (genvar r = 0; r < rows_p; r++) begin : g_row
    localparam int unsigned row_idx = r;
    logic               act_c;
    logic [e_w-1:0]     idx_c;

    assign act_c = (state_q == STREAM) && (t_ext >= row_idx) &&
                   ((t_ext - row_idx) < depth_p);
    assign idx_c = e_w'(row_idx * depth_p + t_ext - row_idx);

    assign valid_o[r]                      = act_c;
    assign data_o[r*width_p +: width_p]    = act_c ? buf_q[idx_c] : '0;
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: a 2x2 instance and a 3x2
// instance share clock and reset; expected wavefronts are queued when a
// matrix is loaded and popped one entry per cycle while it streams.
module tb_systolic_skew_feeder;

  typedef struct packed {
    logic [2:0]  valid;
    logic [23:0] data;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        en_a, flush_a, valid_a, ready_a, done_a;
  logic [7:0]  data_a;
  logic [1:0]  vo_a;
  logic [15:0] do_a;

  logic        en_b, flush_b, valid_b, ready_b, done_b;
  logic [7:0]  data_b;
  logic [2:0]  vo_b;
  logic [23:0] do_b;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  systolic_skew_feeder #(.width_p(8), .rows_p(2), .depth_p(2)) u_a (
    .clk_i(clk), .reset_ni(rst_n), .en_i(en_a), .flush_i(flush_a),
    .valid_i(valid_a), .data_i(data_a), .ready_o(ready_a),
    .valid_o(vo_a), .data_o(do_a), .done_o(done_a)
  );

  systolic_skew_feeder #(.width_p(8), .rows_p(3), .depth_p(2)) u_b (
    .clk_i(clk), .reset_ni(rst_n), .en_i(en_b), .flush_i(flush_b),
    .valid_i(valid_b), .data_i(data_b), .ready_o(ready_b),
    .valid_o(vo_b), .data_o(do_b), .done_o(done_b)
  );

  // Expected wavefront for elements base, base+1, ... (depth 2).
  function automatic void push_model(input bit sel, input int base);
    int   rows = sel ? 3 : 2;
    exp_t e;
    for (int t = 0; t <= rows; t++) begin
      e = '0;
      for (int r = 0; r < rows; r++) begin
        if (t >= r && t - r < 2) begin
          e.valid[2'(r)]    = 1'b1;
          e.data[r*8 +: 8]  = 8'(base + r * 2 + (t - r));
        end
      end
      q.push_back(e);
    end
    e = '0;
    e.done = 1'b1;
    q.push_back(e);
  endfunction

  // Stream a full matrix in; returns at the first wavefront cycle.
  task automatic load_matrix(input bit sel, input int base, input bit gapped);
    int   n = sel ? 6 : 4;
    logic rdy;
    logic [2:0] vo;
    push_model(sel, base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (gapped) begin
        if (sel) valid_b = 1'b0; else valid_a = 1'b0;
        #1;
        rdy = sel ? ready_b : ready_a;
        checks++;
        if (rdy !== 1'b1) begin
          errors++;
          $display("FAIL load_gap_ready sel=%0d elem=%0d got=%b exp=1", sel, i, rdy);
        end
        @(negedge clk);
      end
      if (sel) begin valid_b = 1'b1; data_b = 8'(base + i); end
      else     begin valid_a = 1'b1; data_a = 8'(base + i); end
      #1;
      rdy = sel ? ready_b : ready_a;
      vo  = sel ? vo_b : {1'b0, vo_a};
      checks++;
      if (rdy !== 1'b1 || vo !== 3'b000) begin
        errors++;
        $display("FAIL load_ready sel=%0d elem=%0d ready=%b valid_o=%b exp ready=1 valid_o=000",
                 sel, i, rdy, vo);
      end
    end
    @(negedge clk);
    if (sel) valid_b = 1'b0; else valid_a = 1'b0;
  endtask

  // Pop the scoreboard one entry per cycle, then expect LOAD with ready.
  task automatic check_wave(input bit sel);
    exp_t e, got;
    logic rdy;
    while (q.size() > 0) begin
      e   = q.pop_front();
      got = sel ? {vo_b, do_b, done_b} : {1'b0, vo_a, 8'h00, do_a, done_a};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL wave sel=%0d valid=%b/%b data=%h/%h done=%b/%b (got/exp)",
                 sel, got.valid, e.valid, got.data, e.data, got.done, e.done);
      end
      @(negedge clk);
    end
    #1;
    rdy = sel ? ready_b : ready_a;
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL post_done_ready sel=%0d got=%b exp=1", sel, rdy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en_a = 1'b1; flush_a = 1'b0; valid_a = 1'b0; data_a = '0;
    en_b = 1'b1; flush_b = 1'b0; valid_b = 1'b0; data_b = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({ready_a, vo_a, do_a, done_a} !== '0 || {ready_b, vo_b, do_b, done_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs a=%b/%b/%h/%b b=%b/%b/%h/%b exp all 0",
               ready_a, vo_a, do_a, done_a, ready_b, vo_b, do_b, done_b);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready a=%b b=%b exp 1", ready_a, ready_b);
    end
  endtask

  task automatic test_basic();
    load_matrix(1'b0, 1, 1'b0);
    check_wave(1'b0);
  endtask

  task automatic test_gapped();
    load_matrix(1'b0, 1, 1'b1);
    check_wave(1'b0);
  endtask

  task automatic test_stall();
    exp_t e, got;
    load_matrix(1'b0, 30, 1'b0);
    e   = q.pop_front();
    got = {1'b0, vo_a, 8'h00, do_a, done_a};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL stall_t0 valid=%b/%b data=%h/%h (got/exp)", got.valid, e.valid, got.data, e.data);
    end
    @(negedge clk);
    e   = q.pop_front();
    got = {1'b0, vo_a, 8'h00, do_a, done_a};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL stall_t1 valid=%b/%b data=%h/%h (got/exp)", got.valid, e.valid, got.data, e.data);
    end
    en_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      got = {1'b0, vo_a, 8'h00, do_a, done_a};
      checks++;
      if (got !== e || ready_a !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d valid=%b/%b data=%h/%h ready=%b/0 (got/exp)",
                 k, got.valid, e.valid, got.data, e.data, ready_a);
      end
    end
    en_a = 1'b1;
    @(negedge clk);
    check_wave(1'b0);
  endtask

  task automatic test_flush();
    exp_t e, got;
    load_matrix(1'b0, 1, 1'b0);
    e   = q.pop_front();
    got = {1'b0, vo_a, 8'h00, do_a, done_a};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL flush_t0 valid=%b/%b data=%h/%h (got/exp)", got.valid, e.valid, got.data, e.data);
    end
    @(negedge clk);
    e   = q.pop_front();
    got = {1'b0, vo_a, 8'h00, do_a, done_a};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL flush_t1 valid=%b/%b data=%h/%h (got/exp)", got.valid, e.valid, got.data, e.data);
    end
    flush_a = 1'b1;
    @(negedge clk);
    flush_a = 1'b0;
    #1;
    checks++;
    if (vo_a !== 2'b00 || ready_a !== 1'b1 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL flush_abort valid=%b/00 ready=%b/1 done=%b/0 (got/exp)", vo_a, ready_a, done_a);
    end
    q.delete();
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0 || vo_a !== 2'b00) begin
      errors++;
      $display("FAIL flush_no_done done=%b/0 valid=%b/00 (got/exp)", done_a, vo_a);
    end
    load_matrix(1'b0, 5, 1'b0);
    check_wave(1'b0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    valid_a = 1'b1; data_a = 8'd20;
    @(negedge clk);
    data_a = 8'd21;
    @(negedge clk);
    valid_a = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready_a, vo_a, do_a, done_a} !== '0) begin
      errors++;
      $display("FAIL async_reset ready=%b valid=%b data=%h done=%b exp all 0", ready_a, vo_a, do_a, done_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load_matrix(1'b0, 9, 1'b0);
    check_wave(1'b0);
  endtask

  task automatic test_nonsquare();
    load_matrix(1'b1, 1, 1'b0);
    check_wave(1'b1);
  endtask

  task automatic test_back_to_back();
    load_matrix(1'b1, 40, 1'b0);
    check_wave(1'b1);
    load_matrix(1'b1, 50, 1'b1);
    check_wave(1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_stall();
    test_flush();
    test_async_reset();
    test_nonsquare();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Operand loader for the systolic array. It accepts one `rows_p` x `depth_p` operand matrix as a serial row-major stream over a valid/ready handshake and buffers it. It then replays the matrix onto the array's row inputs as a diagonal wavefront, with row `r` delayed `r` cycles. It sits between the host-side stream and the array's west (or north) edge in `top`, generalising the fixed 2x2 feed to any array height and inner dimension, with stall (`en_i`) and abort (`flush_i`) control.

## Interface
- `width_p`, 8, element width in bits
- `rows_p`, 2, array rows fed (array_height_p); >= 1
- `depth_p`, 2, inner dimension K, elements per row; >= 1

- `clk_i`  in  1  clock, all state on rising edge
- `reset_ni`  in  1  asynchronous active-low reset
- `en_i`  in  1  global enable; 0 freezes all state
- `flush_i`  in  1  synchronous abort to LOAD
- `valid_i`  in  1  input element valid
- `data_i`  in  `width_p`  input element, row-major order
- `ready_o`  out  1  block accepts element this cycle
- `valid_o`  out  `rows_p`  per-row output valid, bit r = row r
- `data_o`  out  `rows_p*width_p`  row r at bits [r*width_p +: width_p]
- `done_o`  out  1  one-cycle pulse after wavefront completes

## Operation
- States: LOAD, STREAM, DONE. Reset state LOAD.
- LOAD: `ready_o = en_i`. A transfer occurs when `valid_i && ready_o`. Element index `e` counts 0 .. `rows_p*depth_p-1`. Element e is stored at row `e / depth_p`, column `e % depth_p`. The transfer with `e = rows_p*depth_p-1` moves the block to STREAM and clears `e`.
- STREAM: cycle counter `t` runs 0 .. `rows_p+depth_p-2`. Row r is active when `0 <= t-r < depth_p`. An active row drives `valid_o[r]=1` and `data_o` row r = buf[r][t-r]. An inactive row drives `valid_o[r]=0` and `data_o` row r = 0. At `t = rows_p+depth_p-2` the block moves to DONE and clears `t`. `ready_o=0`.
- DONE: `done_o=1`, `valid_o=0`, `data_o=0`, `ready_o=0`. The block unconditionally moves to LOAD on the next enabled edge.
- `en_i=0`: state, `e`, `t` and the buffer all hold, and `ready_o=0`. Outputs keep their current values, since they are a function of state. A stalled STREAM cycle therefore repeats identical `valid_o`/`data_o`, and downstream must gate on `en_i` as well.
- `flush_i=1` on an edge: state goes to LOAD and `e`, `t` clear, regardless of `en_i`. Buffer contents are not cleared (don't-care). Any in-flight transfer on that edge is dropped. `flush_i` has priority over all other events.
- Counter widths: `e` is `$clog2(rows_p*depth_p)`, minimum 1 bit. `t` is `$clog2(rows_p+depth_p-1)`, minimum 1 bit. No wrap-around beyond the terminal values.

## Timing
- Reset (`reset_ni=0`): state LOAD, `e=t=0`, `ready_o=0` (forced while in reset), `valid_o=0`, `data_o=0`, `done_o=0`.
- Input side: `ready_o` is combinational from state and `en_i`; it does not depend on `valid_i`.
- Latency: the last accept happens at edge E. The first wavefront cycle (`t=0`) is the cycle after E. STREAM lasts `rows_p+depth_p-1` enabled cycles, and DONE lasts 1.
- Throughput: one matrix per `rows_p*depth_p + rows_p + depth_p` enabled cycles. There is no load/stream overlap.
- Degenerate case `rows_p=depth_p=1`: STREAM lasts a single cycle with `valid_o=1`.

## Structure
- Shared package `systolic_pkg`:
  - `skew_state_e` enum (LOAD, STREAM, DONE).
  - Helper localparam functions for counter widths.
- Buffer is a flat register array `rows_p*depth_p` x `width_p`, written by index `e`; it needs no reset.
- One natural sub-module, `counter_up` (parametrised max value, enable, clear, terminal flag), instantiated twice: once for `e` and once for `t`.

## Test plan
- Basic 2x2 (width 8): load 1,2,3,4 with continuous `valid_i`. Required response, cycle by cycle:
  - t0: `valid_o=01`, row0=1, row1=0.
  - t1: `valid_o=11`, row0=2, row1=3.
  - t2: `valid_o=10`, row0=0, row1=4.
  - next cycle: `done_o=1`.
  - following cycle: `ready_o=1`.
- Gapped input: toggle `valid_i` every other cycle while loading 1..4. Required: the same wavefront as the basic case, and `ready_o` stays 1 throughout LOAD.
- Stall: drop `en_i` for 3 cycles at STREAM t1. Required: `valid_o=11`, row0=2, row1=3 held for 4 cycles total, then t2 proceeds normally.
- Flush: assert `flush_i` at STREAM t1. Required: next cycle `valid_o=00` and `ready_o=1`, with no `done_o`. Then load 5..8 and check the wavefront is 5 / 6,7 / 8.
- Async reset mid-LOAD after 2 elements: all outputs go to 0 immediately. After release, a fresh 4-element load is required before any `valid_o`.
- Non-square, `rows_p=3`, `depth_p=2`: load 1..6. Required:
  - t0: `valid_o=001`, row0=1.
  - t1: `valid_o=011`, rows 2/3.
  - t2: `valid_o=110`, rows 0/4/5.
  - t3: `valid_o=100`, row2=6.
  - next cycle: `done_o=1`.
